// File: rtl/core_status_ctl.sv
// Shared types and constants for the processor status block:
// flag operation codes, interrupt vector selection and P bit positions.
package core_status_ctl;

    typedef enum logic [2:0] {
        FLAG_NONE = 3'd0,
        FLAG_SEI  = 3'd1,
        FLAG_CLI  = 3'd2,
        FLAG_SED  = 3'd3,
        FLAG_CLD  = 3'd4
    } flag_op_type;

    typedef enum logic [1:0] {
        VEC_NONE  = 2'd0,
        VEC_RESET = 2'd1,
        VEC_NMI   = 2'd2,
        VEC_IRQ   = 2'd3
    } vector_type;

    localparam int P_C = 0;
    localparam int P_Z = 1;
    localparam int P_I = 2;
    localparam int P_D = 3;
    localparam int P_B = 4;
    localparam int P_U = 5;
    localparam int P_V = 6;
    localparam int P_N = 7;

    // Assemble a P byte in N V 1 B D I Z C order; bit 5 always reads as 1.
    function automatic logic [7:0] pack_p(input logic n, input logic v, input logic b,
                                          input logic d, input logic i, input logic z,
                                          input logic c);
        logic [7:0] p;
        p      = 8'h00;
        p[P_N] = n;
        p[P_V] = v;
        p[P_U] = 1'b1;
        p[P_B] = b;
        p[P_D] = d;
        p[P_I] = i;
        p[P_Z] = z;
        p[P_C] = c;
        return p;
    endfunction

endpackage

// File: rtl/core_edge_detect.sv
// Falling-edge detector with a sticky latch for the active-low NMI line.
// It runs on every clock regardless of the CPU clock enable so that a short
// NMI pulse during a stalled cycle is never lost.
module core_edge_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic level_n,
    input  logic clear,
    output logic latch
);

    logic prev;
    logic fall;

    assign fall = prev & ~level_n;

    // Track the previous line level; a new falling edge wins over a clear in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            prev  <= 1'b1;
            latch <= 1'b0;
        end else begin
            prev  <= level_n;
            latch <= fall | (latch & ~clear);
        end
    end

endmodule

// File: rtl/core_status.sv
// Processor status register (P) plus interrupt poll logic.
// Holds N V D I Z C, exposes P for reads and pushes, and resolves pending
// RESET / NMI / IRQ requests at instruction-boundary polls.
module core_status
    import core_status_ctl::*;
(
    input  logic        I_clock,
    input  logic        I_reset_n,
    input  logic        I_ready,
    input  logic        I_alu_carry,
    input  logic        I_alu_overflow,
    input  logic        I_alu_sign,
    input  logic        I_alu_zero,
    input  logic        I_alu_write,
    input  logic        I_p_load,
    input  logic [7:0]  I_data,
    input  flag_op_type I_flag_op,
    input  logic        I_push_brk,
    input  logic        I_nmi_n,
    input  logic        I_irq_n,
    input  logic        I_poll,
    input  logic        I_int_ack,
    output logic        O_carry,
    output logic        O_overflow,
    output logic        O_sign,
    output logic        O_zero,
    output logic [7:0]  O_p,
    output logic [7:0]  O_push_data,
    output logic        O_int_pending,
    output vector_type  O_vector
);

    logic       flag_c;
    logic       flag_z;
    logic       flag_i;
    logic       flag_d;
    logic       flag_v;
    logic       flag_n;
    logic       i_shadow;
    logic       reset_pending;
    logic       nmi_latch;
    logic       nmi_clear;
    vector_type poll_pick;
    logic       unused_data_bits;

    // Bits 5 (always 1) and 4 (B, not stored) of a pulled P byte are ignored.
    assign unused_data_bits = ^I_data[P_U:P_B];

    // Only an acknowledged NMI vector consumes the NMI latch.
    assign nmi_clear = I_ready & I_int_ack & (O_vector == VEC_NMI);

    core_edge_detect u_nmi_edge (
        .clock   (I_clock),
        .reset_n (I_reset_n),
        .level_n (I_nmi_n),
        .clear   (nmi_clear),
        .latch   (nmi_latch)
    );

    // Flag register: pulled P beats ALU results, ack forces I, shadow I lags by one cycle.
    always_ff @(posedge I_clock) begin
        if (!I_reset_n) begin
            flag_c   <= 1'b0;
            flag_z   <= 1'b0;
            flag_v   <= 1'b0;
            flag_n   <= 1'b0;
            flag_d   <= 1'b0;
            flag_i   <= 1'b1;
            i_shadow <= 1'b1;
        end else if (I_ready) begin
            if (I_p_load) begin
                flag_c <= I_data[P_C];
                flag_z <= I_data[P_Z];
                flag_v <= I_data[P_V];
                flag_n <= I_data[P_N];
            end else if (I_alu_write) begin
                flag_c <= I_alu_carry;
                flag_z <= I_alu_zero;
                flag_v <= I_alu_overflow;
                flag_n <= I_alu_sign;
            end

            if (I_p_load) begin
                flag_d <= I_data[P_D];
            end else if (I_flag_op == FLAG_SED) begin
                flag_d <= 1'b1;
            end else if (I_flag_op == FLAG_CLD) begin
                flag_d <= 1'b0;
            end

            if (I_int_ack) begin
                flag_i <= 1'b1;
            end else if (I_p_load) begin
                flag_i <= I_data[P_I];
            end else if (I_flag_op == FLAG_SEI) begin
                flag_i <= 1'b1;
            end else if (I_flag_op == FLAG_CLI) begin
                flag_i <= 1'b0;
            end

            i_shadow <= flag_i;
        end
    end

    // Choose the highest-priority request that a poll would capture this cycle.
    always_comb begin
        poll_pick = VEC_NONE;
        if (reset_pending) begin
            poll_pick = VEC_RESET;
        end else if (nmi_latch) begin
            poll_pick = VEC_NMI;
        end else if (~I_irq_n & ~i_shadow) begin
            poll_pick = VEC_IRQ;
        end
    end

    // Poll result register: ack clears and beats poll; reset presents VEC_RESET immediately.
    always_ff @(posedge I_clock) begin
        if (!I_reset_n) begin
            reset_pending <= 1'b1;
            O_vector      <= VEC_RESET;
            O_int_pending <= 1'b1;
        end else if (I_ready) begin
            if (I_int_ack) begin
                if (O_vector == VEC_RESET) begin
                    reset_pending <= 1'b0;
                end
                O_vector      <= VEC_NONE;
                O_int_pending <= 1'b0;
            end else if (I_poll) begin
                O_vector      <= poll_pick;
                O_int_pending <= (poll_pick != VEC_NONE);
            end
        end
    end

    assign O_carry     = flag_c;
    assign O_overflow  = flag_v;
    assign O_sign      = flag_n;
    assign O_zero      = flag_z;
    assign O_p         = pack_p(flag_n, flag_v, 1'b0, flag_d, flag_i, flag_z, flag_c);
    assign O_push_data = pack_p(flag_n, flag_v, I_push_brk, flag_d, flag_i, flag_z, flag_c);

endmodule

// File: tb/tb_core_status.sv
// Directed bench for core_status with a scoreboard: stimulus pushes the
// hand-computed expected values, a negedge monitor pops and compares them.
module tb_core_status;
    import core_status_ctl::*;

    typedef enum {K_P, K_VEC, K_PEND, K_PUSH, K_FLAGS} kind_t;

    typedef struct {
        int         due;
        string      name;
        kind_t      kind;
        logic [7:0] want;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic        ready;
    logic        alu_carry;
    logic        alu_overflow;
    logic        alu_sign;
    logic        alu_zero;
    logic        alu_write;
    logic        p_load;
    logic [7:0]  data;
    flag_op_type flag_op;
    logic        push_brk;
    logic        nmi_n;
    logic        irq_n;
    logic        poll;
    logic        int_ack;
    logic        carry;
    logic        overflow;
    logic        sign;
    logic        zero;
    logic [7:0]  p;
    logic [7:0]  push_data;
    logic        int_pending;
    vector_type  vector;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    core_status dut (
        .I_clock        (clock),
        .I_reset_n      (reset_n),
        .I_ready        (ready),
        .I_alu_carry    (alu_carry),
        .I_alu_overflow (alu_overflow),
        .I_alu_sign     (alu_sign),
        .I_alu_zero     (alu_zero),
        .I_alu_write    (alu_write),
        .I_p_load       (p_load),
        .I_data         (data),
        .I_flag_op      (flag_op),
        .I_push_brk     (push_brk),
        .I_nmi_n        (nmi_n),
        .I_irq_n        (irq_n),
        .I_poll         (poll),
        .I_int_ack      (int_ack),
        .O_carry        (carry),
        .O_overflow     (overflow),
        .O_sign         (sign),
        .O_zero         (zero),
        .O_p            (p),
        .O_push_data    (push_data),
        .O_int_pending  (int_pending),
        .O_vector       (vector)
    );

    // Free-running clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Cycle counter used to schedule scoreboard entries.
    always @(posedge clock) begin
        cyc <= cyc + 1;
    end

    task automatic push_exp(input string name, input kind_t kind, input logic [7:0] want,
                            input int delay);
        exp_t e;
        e.due  = cyc + delay;
        e.name = name;
        e.kind = kind;
        e.want = want;
        sb.push_back(e);
    endtask

    task automatic exp_vec(input string name, input vector_type v, input logic pend);
        push_exp({name, "_vec"}, K_VEC, {6'b0, v}, 1);
        push_exp({name, "_pend"}, K_PEND, {7'b0, pend}, 1);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        alu_write = 1'b0;
        p_load    = 1'b0;
        data      = 8'h00;
        flag_op   = FLAG_NONE;
        poll      = 1'b0;
        int_ack   = 1'b0;
        push_brk  = 1'b0;
    endtask

    task automatic check_output(input exp_t e);
        logic [7:0] act;
        act = 8'h00;
        case (e.kind)
            K_P:     act = p;
            K_VEC:   act = {6'b0, vector};
            K_PEND:  act = {7'b0, int_pending};
            K_PUSH:  act = push_data;
            K_FLAGS: act = {4'b0, sign, overflow, zero, carry};
            default: act = 8'hxx;
        endcase
        checks++;
        if (act !== e.want) begin
            failures++;
            $display("[TB] FAIL %s: got %h want %h (cycle %0d)", e.name, act, e.want, cyc);
        end
    endtask

    // Monitor: compare every scoreboard entry that has come due.
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            check_output(sb.pop_front());
        end
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        int guard;
        idle();
        reset_n      = 1'b0;
        ready        = 1'b1;
        nmi_n        = 1'b1;
        irq_n        = 1'b1;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        alu_sign     = 1'b0;
        alu_zero     = 1'b0;
        tick();
        tick();

        ready     = 1'b0;
        alu_write = 1'b1;
        alu_carry = 1'b1;
        push_exp("rst_p", K_P, 8'h24, 1);
        exp_vec("rst", VEC_RESET, 1'b1);
        tick();
        idle();
        ready     = 1'b1;
        alu_carry = 1'b0;

        reset_n = 1'b1;
        poll    = 1'b1;
        exp_vec("post_rst_poll", VEC_RESET, 1'b1);
        tick();

        idle();
        int_ack = 1'b1;
        exp_vec("rst_ack", VEC_NONE, 1'b0);
        push_exp("rst_ack_p", K_P, 8'h24, 1);
        tick();

        idle();
        push_brk = 1'b1;
        push_exp("push_brk1", K_PUSH, 8'h34, 0);
        tick();
        push_brk = 1'b0;
        push_exp("push_brk0", K_PUSH, 8'h24, 0);
        tick();

        alu_write    = 1'b1;
        alu_sign     = 1'b1;
        alu_zero     = 1'b0;
        alu_carry    = 1'b1;
        alu_overflow = 1'b0;
        push_exp("alu_p", K_P, 8'hA5, 1);
        push_exp("alu_flags", K_FLAGS, 8'h09, 1);
        tick();
        p_load = 1'b1;
        data   = 8'h00;
        push_exp("pload_over_alu", K_P, 8'h20, 1);
        tick();
        idle();
        alu_sign  = 1'b0;
        alu_carry = 1'b0;

        flag_op = FLAG_SEI;
        push_exp("sei_p", K_P, 8'h24, 1);
        tick();
        idle();
        tick();

        irq_n   = 1'b0;
        flag_op = FLAG_CLI;
        push_exp("cli_p", K_P, 8'h20, 1);
        tick();
        idle();
        poll = 1'b1;
        exp_vec("irq_poll_t1", VEC_NONE, 1'b0);
        tick();
        poll = 1'b1;
        exp_vec("irq_poll_t2", VEC_IRQ, 1'b1);
        tick();

        idle();
        int_ack = 1'b1;
        exp_vec("irq_ack", VEC_NONE, 1'b0);
        push_exp("irq_ack_p", K_P, 8'h24, 1);
        tick();
        idle();
        flag_op = FLAG_CLI;
        push_exp("cli2_p", K_P, 8'h20, 1);
        tick();
        idle();
        tick();

        ready     = 1'b0;
        nmi_n     = 1'b0;
        alu_write = 1'b1;
        alu_carry = 1'b1;
        poll      = 1'b1;
        push_exp("stall_p_hold", K_P, 8'h20, 1);
        exp_vec("stall_poll", VEC_NONE, 1'b0);
        tick();
        idle();
        ready     = 1'b1;
        alu_carry = 1'b0;
        poll      = 1'b1;
        exp_vec("nmi_over_irq", VEC_NMI, 1'b1);
        tick();

        idle();
        nmi_n = 1'b1;
        tick();
        int_ack = 1'b1;
        nmi_n   = 1'b0;
        exp_vec("nmi_ack_edge", VEC_NONE, 1'b0);
        tick();
        idle();
        irq_n = 1'b1;
        poll  = 1'b1;
        exp_vec("nmi_again", VEC_NMI, 1'b1);
        tick();
        idle();
        int_ack = 1'b1;
        exp_vec("nmi_ack2", VEC_NONE, 1'b0);
        tick();
        idle();
        poll = 1'b1;
        exp_vec("nmi_cleared", VEC_NONE, 1'b0);
        tick();

        idle();
        nmi_n = 1'b1;
        tick();
        nmi_n = 1'b0;
        tick();
        poll = 1'b1;
        exp_vec("nmi3", VEC_NMI, 1'b1);
        tick();
        int_ack = 1'b1;
        poll    = 1'b1;
        exp_vec("ack_beats_poll", VEC_NONE, 1'b0);
        tick();
        idle();
        poll = 1'b1;
        exp_vec("after_ack_poll", VEC_NONE, 1'b0);
        tick();

        idle();
        flag_op = FLAG_SED;
        push_exp("sed_p", K_P, 8'h2C, 1);
        tick();
        flag_op = FLAG_CLD;
        p_load  = 1'b1;
        data    = 8'hFF;
        push_exp("pload_over_cld", K_P, 8'hEF, 1);
        tick();
        idle();
        flag_op = FLAG_CLD;
        push_exp("cld_p", K_P, 8'hE7, 1);
        tick();
        flag_op = FLAG_SEI;
        p_load  = 1'b1;
        data    = 8'h00;
        push_exp("pload_over_sei", K_P, 8'h20, 1);
        tick();
        idle();
        p_load  = 1'b1;
        int_ack = 1'b1;
        push_exp("ack_over_pload", K_P, 8'h24, 1);
        tick();

        idle();
        nmi_n = 1'b1;
        tick();
        nmi_n   = 1'b0;
        reset_n = 1'b0;
        ready   = 1'b0;
        push_exp("rst2_p", K_P, 8'h24, 1);
        exp_vec("rst2", VEC_RESET, 1'b1);
        tick();
        reset_n = 1'b1;
        ready   = 1'b1;
        nmi_n   = 1'b1;
        tick();
        int_ack = 1'b1;
        exp_vec("rst2_ack", VEC_NONE, 1'b0);
        tick();
        idle();
        poll = 1'b1;
        exp_vec("rst_discard_nmi", VEC_NONE, 1'b0);
        tick();
        idle();

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            tick();
            guard++;
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain: got %0d pending want 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
